// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter
//   Shares the single-port display RAM between the video fetch path and the
//   CPU/host port. Video normally wins; a saturating wait counter forces a CPU
//   slot once the CPU has been blocked for CPU_MAX_WAIT cycles. One access is
//   issued per cycle and its result is returned exactly one cycle later.
//   Optional feature: define VBLANK_ONLY_WR_EN to restrict CPU writes to the
//   vertical blanking interval (CPU reads stay unrestricted).
module frame_ram_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 65,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_gnt_o,
  output logic              vid_valid_o,
  output logic [DATA_W-1:0] vid_data_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              vblank_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int                WAIT_W   = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  logic              vidReq;
  logic              cpuReq;
  logic              wrWindow;
  logic              cpuElig;
  logic              cpuWin;
  logic              vidWin;
  logic              vidInRange;
  logic              cpuInRange;

  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              vidRet_q, vidRet_d;
  logic              vidHit_q, vidHit_d;
  logic              cpuRet_q, cpuRet_d;
  logic              cpuRdHit_q, cpuRdHit_d;

  // Requests are masked while reset is asserted so grants and the RAM port
  // drop to zero immediately, not only at the next clock edge.
  assign vidReq = vid_req_i & rst_n;
  assign cpuReq = cpu_req_i & rst_n;

`ifdef VBLANK_ONLY_WR_EN
  // Writes may only compete for the RAM while the display is blanked.
  assign wrWindow = vblank_i;
`else
  // vblank has no influence on arbitration in this build; it is folded into a
  // constant-true window so the port remains connected.
  assign wrWindow = vblank_i | 1'b1;
`endif

  // A CPU request that is outside its write window is not competing at all:
  // it gets no grant and does not advance the starvation counter.
  assign cpuElig = cpuReq & (~cpu_we_i | wrWindow);

  assign vidInRange = ({1'b0, vid_addr_i} < DEPTH_L);
  assign cpuInRange = ({1'b0, cpu_addr_i} < DEPTH_L);

  // Grant decision: video first, unless the CPU has waited the maximum time.
  always_comb begin
    cpuWin = cpuElig & (~vidReq | (waitCnt_q == WAIT_MAX));
    vidWin = vidReq & ~cpuWin;
  end

  assign vid_gnt_o = vidWin;
  assign cpu_gnt_o = cpuWin;

  // RAM port steering; out-of-range accesses are granted but never reach the RAM.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (cpuWin) begin
      mem_en_o    = cpuInRange;
      mem_we_o    = cpuInRange & cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_we_i ? cpu_wdata_i : '0;
    end else if (vidWin) begin
      mem_en_o   = vidInRange;
      mem_addr_o = vid_addr_i;
    end
  end

  // Starvation counter: counts blocked eligible CPU cycles, saturates, clears on grant.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (cpuWin) begin
      waitCnt_d = '0;
    end else if (cpuElig && (waitCnt_q != WAIT_MAX)) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end
  end

  // Return-stage flags describing what this cycle's access will deliver next cycle.
  always_comb begin
    vidRet_d   = vidWin;
    vidHit_d   = vidWin & vidInRange;
    cpuRet_d   = cpuWin;
    cpuRdHit_d = cpuWin & ~cpu_we_i & cpuInRange;
  end

  // State registers; reset drops any return that is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt_q  <= '0;
      vidRet_q   <= 1'b0;
      vidHit_q   <= 1'b0;
      cpuRet_q   <= 1'b0;
      cpuRdHit_q <= 1'b0;
    end else begin
      waitCnt_q  <= waitCnt_d;
      vidRet_q   <= vidRet_d;
      vidHit_q   <= vidHit_d;
      cpuRet_q   <= cpuRet_d;
      cpuRdHit_q <= cpuRdHit_d;
    end
  end

  // Return outputs: RAM data is passed through only for in-range reads, else 0.
  always_comb begin
    vid_valid_o = vidRet_q;
    vid_data_o  = vidHit_q ? mem_rdata_i : '0;
    cpu_ack_o   = cpuRet_q;
    cpu_rdata_o = cpuRdHit_q ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// tb_frame_ram_arbiter
//   Directed plus short random stimulus for frame_ram_arbiter. A behavioural
//   synchronous RAM answers the DUT's memory port; a shadow copy of the memory
//   and a return queue hold the expected read data for every grant.
module tb_frame_ram_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 65;
  localparam int MAXW   = 8;

  typedef struct {
    bit                isCpu;
    logic [DATA_W-1:0] data;
  } ret_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vblank;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  ret_t              sb[$];
  int                vectors = 0;
  int                miscompares = 0;
  logic [DATA_W-1:0] shadow [128];
  int                mWait;
  bit                expVidG;
  bit                expCpuG;
  logic              dutCpuG;
  logic [DATA_W-1:0] lastCpuRdata;
  int                waitCycles;

  logic              ramClr;
  logic [DATA_W-1:0] ram [128];
  logic [127:0]      ramWr;

  frame_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CPU_MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_gnt_o(vid_gnt),
    .vid_valid_o(vid_valid), .vid_data_o(vid_data),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_gnt_o(cpu_gnt), .cpu_ack_o(cpu_ack),
    .cpu_rdata_o(cpu_rdata), .vblank_i(vblank),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] initVal(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] t;
    t = {1'b0, a};
    return t * 8'd3 + 8'd7;
  endfunction

  // Synchronous single-port RAM: unwritten words read back as initVal(addr).
  always @(posedge clk) begin
    if (ramClr) begin
      ramWr <= '0;
    end else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]   <= mem_wdata;
        ramWr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ramWr[mem_addr] ? ram[mem_addr] : initVal(mem_addr);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_vid_gnt"},   32'(vid_gnt),   32'd0);
    checkOutput({tag, "_vid_valid"}, 32'(vid_valid), 32'd0);
    checkOutput({tag, "_vid_data"},  32'(vid_data),  32'd0);
    checkOutput({tag, "_cpu_gnt"},   32'(cpu_gnt),   32'd0);
    checkOutput({tag, "_cpu_ack"},   32'(cpu_ack),   32'd0);
    checkOutput({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    checkOutput({tag, "_mem_en"},    32'(mem_en),    32'd0);
    checkOutput({tag, "_mem_we"},    32'(mem_we),    32'd0);
    checkOutput({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  // One clock cycle: check returns owed from last cycle, predict and check this
  // cycle's grants and RAM port, queue the expected return, advance the model.
  task automatic applyStimulus();
    ret_t e;
    bit   inr;
    bit   cpuElig;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.isCpu) begin
        checkOutput("cpu_ack",        32'(cpu_ack),   32'd1);
        checkOutput("vid_valid_quiet", 32'(vid_valid), 32'd0);
        checkOutput("cpu_rdata",      32'(cpu_rdata), 32'(e.data));
      end else begin
        checkOutput("vid_valid",      32'(vid_valid), 32'd1);
        checkOutput("cpu_ack_quiet",  32'(cpu_ack),   32'd0);
        checkOutput("vid_data",       32'(vid_data),  32'(e.data));
      end
    end else begin
      checkOutput("vid_valid_none", 32'(vid_valid), 32'd0);
      checkOutput("cpu_ack_none",   32'(cpu_ack),   32'd0);
    end

    cpuElig = cpu_req;
`ifdef VBLANK_ONLY_WR_EN
    if (cpu_we && !vblank) cpuElig = 1'b0;
`endif
    expCpuG = cpuElig && (!vid_req || mWait == MAXW);
    expVidG = vid_req && !expCpuG;
    checkOutput("vid_gnt", 32'(vid_gnt), 32'(expVidG));
    checkOutput("cpu_gnt", 32'(cpu_gnt), 32'(expCpuG));
    dutCpuG      = cpu_gnt;
    lastCpuRdata = cpu_rdata;

    if (expCpuG) begin
      inr = int'(cpu_addr) < DEPTH;
      checkOutput("mem_en_cpu", 32'(mem_en), 32'(inr));
      checkOutput("mem_we_cpu", 32'(mem_we), 32'(inr && cpu_we));
      if (inr) checkOutput("mem_addr_cpu", 32'(mem_addr), 32'(cpu_addr));
      if (inr && cpu_we) checkOutput("mem_wdata_cpu", 32'(mem_wdata), 32'(cpu_wdata));
      e.isCpu = 1'b1;
      e.data  = (inr && !cpu_we) ? shadow[cpu_addr] : 8'h00;
      sb.push_back(e);
      if (inr && cpu_we) shadow[cpu_addr] = cpu_wdata;
    end else if (expVidG) begin
      inr = int'(vid_addr) < DEPTH;
      checkOutput("mem_en_vid", 32'(mem_en), 32'(inr));
      checkOutput("mem_we_vid", 32'(mem_we), 32'd0);
      if (inr) checkOutput("mem_addr_vid", 32'(mem_addr), 32'(vid_addr));
      e.isCpu = 1'b0;
      e.data  = inr ? shadow[vid_addr] : 8'h00;
      sb.push_back(e);
    end else begin
      checkOutput("mem_en_idle", 32'(mem_en), 32'd0);
    end

    if (expCpuG) mWait = 0;
    else if (cpuElig && mWait < MAXW) mWait++;

    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    ramClr    = 1'b1;
    vid_req   = 1'b0;
    vid_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    vblank    = 1'b0;
    mWait     = 0;
    for (int i = 0; i < 128; i++) shadow[i] = initVal(7'(i));

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    ramClr = 1'b0;
    checkAllZero("reset");
    rst_n = 1'b1;

    // Reset asserted while a video read is in flight
    $display("[TB] reset mid-transfer");
    vid_req  = 1'b1;
    vid_addr = 7'd1;
    applyStimulus();
    rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    sb.delete();
    mWait = 0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    vid_req = 1'b0;
    applyStimulus();
    applyStimulus();

    // Video streaming across the whole address range
    $display("[TB] video sweep");
    vid_req = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      vid_addr = 7'(a);
      applyStimulus();
    end
    vid_req = 1'b0;
    applyStimulus();

    // CPU write starved by continuous video until the wait limit
    $display("[TB] starvation");
    vid_req    = 1'b1;
    cpu_req    = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = 7'd3;
    cpu_wdata  = 8'h5A;
    waitCycles = 0;
    for (int i = 0; i < 20; i++) begin
      vid_addr = 7'(10 + i);
      waitCycles++;
      applyStimulus();
      if (dutCpuG) break;
    end
    checkOutput("t3_cpu_slot", 32'(waitCycles), 32'd9);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    vid_addr = 7'd40;
    applyStimulus();
    vid_addr = 7'd41;
    applyStimulus();
    vid_req = 1'b0;
    applyStimulus();
    cpu_req  = 1'b1;
    cpu_addr = 7'd3;
    applyStimulus();
    cpu_req = 1'b0;
    applyStimulus();
    checkOutput("t3_readback", 32'(lastCpuRdata), 32'h5A);

    // Simultaneous requests from idle: video first, CPU next cycle
    $display("[TB] simultaneous");
    vid_req  = 1'b1;
    vid_addr = 7'd5;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 7'd7;
    applyStimulus();
    vid_req = 1'b0;
    applyStimulus();
    cpu_req = 1'b0;
    applyStimulus();

    // Out-of-range CPU accesses
    $display("[TB] out of range");
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 7'd70;
    applyStimulus();
    cpu_req = 1'b0;
    applyStimulus();
    checkOutput("t5_oor_rdata", 32'(lastCpuRdata), 32'h00);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 7'd65;
    cpu_wdata = 8'hAA;
    applyStimulus();
    cpu_we = 1'b0;
    applyStimulus();
    cpu_addr = 7'd64;
    applyStimulus();
    cpu_req = 1'b0;
    applyStimulus();

`ifdef VBLANK_ONLY_WR_EN
    // Writes held off until vertical blanking
    $display("[TB] vblank write window");
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 7'd9;
    cpu_wdata = 8'h33;
    vblank    = 1'b0;
    repeat (3) begin
      applyStimulus();
      checkOutput("t6_blocked", 32'(dutCpuG), 32'd0);
    end
    vblank = 1'b1;
    applyStimulus();
    checkOutput("t6_vblank_gnt", 32'(dutCpuG), 32'd1);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    vblank  = 1'b0;
    applyStimulus();
`endif

    // Mixed random traffic; requests are held until the model grants them
    $display("[TB] random traffic");
    for (int i = 0; i < 80; i++) begin
      if (!vid_req && $urandom_range(0, 3) != 0) begin
        vid_req  = 1'b1;
        vid_addr = 7'($urandom_range(0, 70));
      end
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 7'($urandom_range(0, 70));
        cpu_wdata = 8'($urandom);
      end
      vblank = 1'($urandom_range(0, 1));
      applyStimulus();
      if (expVidG) vid_req = 1'b0;
      if (expCpuG) cpu_req = 1'b0;
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
    applyStimulus();
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
